// File: rtl/rice_block_sequencer_if.sv
// Stream-in handshake plus decompressor drive bundle for the Rice block sequencer.
// slave = sequencer view, master = upstream buffer / decompressor side.
interface rice_block_sequencer_if;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        dec_first;
    logic        dec_valid;
    logic [31:0] dec_data;
    logic [15:0] dec_data2;
    logic [4:0]  dec_k;
    logic [4:0]  dec_j;
    logic [4:0]  dec_n;
    logic [9:0]  dec_xref;
    logic        dec_block_done;

    modport slave (
        input  s_valid, s_data, dec_block_done,
        output s_ready, dec_first, dec_valid, dec_data, dec_data2,
               dec_k, dec_j, dec_n, dec_xref
    );

    modport master (
        output s_valid, s_data, dec_block_done,
        input  s_ready, dec_first, dec_valid, dec_data, dec_data2,
               dec_k, dec_j, dec_n, dec_xref
    );
endinterface

// File: rtl/rice_block_sequencer.sv
// Parses a two-word block header, then forwards the block payload to the Rice decompressor.
// Latency: payload word appears on dec_data/dec_valid one cycle after its input handshake.
// Backpressure: s_ready low in IDLE/WAIT_DONE and in HDR0 while enable is low; never stalls mid-block.
module rice_block_sequencer #(
    parameter int FIRST_HOLD   = 6,
    parameter int DONE_TIMEOUT = 1023,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [4:0]       cfg_j,
    input  logic [4:0]       cfg_n,
    input  logic             err_clr,
    output logic             busy,
    output logic [CNT_W-1:0] blk_count,
    output logic             err_param,
    output logic             err_timeout,
    rice_block_sequencer_if.slave bus
);
    localparam int TMR_W = $clog2(DONE_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, HDR0, HDR1, STREAM, WAIT_DONE, SKIP} state_t;

    state_t           state_q, state_d;
    logic [4:0]       hdr_k_q, hdr_k_d, hdr_j_q, hdr_j_d, hdr_n_q, hdr_n_d;
    logic             hdr_ref_q, hdr_ref_d;
    logic [9:0]       hdr_xref_q, hdr_xref_d;
    logic [15:0]      hdr_nwords_q, hdr_nwords_d;
    logic [15:0]      beat_q, beat_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             dec_valid_q, dec_valid_d, dec_first_q, dec_first_d;
    logic [31:0]      dec_data_q, dec_data_d;
    logic [15:0]      dec_data2_q, dec_data2_d;
    logic [4:0]       dec_k_q, dec_k_d, dec_j_q, dec_j_d, dec_n_q, dec_n_d;
    logic [9:0]       dec_xref_q, dec_xref_d;
    logic [CNT_W-1:0] blk_count_q, blk_count_d;
    logic             err_param_q, err_param_d, err_timeout_q, err_timeout_d;

    logic s_ready;
    logic hs;
    logic hdr_illegal;
    logic last_beat;

    always_comb begin
        s_ready = 1'b0;
        case (state_q)
            HDR0:                s_ready = enable;
            HDR1, STREAM, SKIP:  s_ready = 1'b1;
            default:             s_ready = 1'b0;
        endcase
    end

    assign hs          = bus.s_valid & s_ready;
    assign hdr_illegal = (hdr_nwords_q == 16'd0) || (hdr_k_q > hdr_n_q) ||
                         (hdr_j_q == 5'd0) || (hdr_n_q == 5'd0);
    assign last_beat   = (beat_q == hdr_nwords_q - 16'd1);

    always_comb begin
        state_d       = state_q;
        hdr_k_d       = hdr_k_q;
        hdr_j_d       = hdr_j_q;
        hdr_n_d       = hdr_n_q;
        hdr_ref_d     = hdr_ref_q;
        hdr_xref_d    = hdr_xref_q;
        hdr_nwords_d  = hdr_nwords_q;
        beat_d        = beat_q;
        timer_d       = timer_q;
        dec_valid_d   = 1'b0;
        dec_first_d   = 1'b0;
        dec_data_d    = dec_data_q;
        dec_data2_d   = dec_data2_q;
        dec_k_d       = dec_k_q;
        dec_j_d       = dec_j_q;
        dec_n_d       = dec_n_q;
        dec_xref_d    = dec_xref_q;
        blk_count_d   = blk_count_q;
        // A new error event in the same cycle as err_clr must leave the flag set.
        err_param_d   = err_param_q & ~err_clr;
        err_timeout_d = err_timeout_q & ~err_clr;

        case (state_q)
            IDLE: state_d = HDR0;
            HDR0: begin
                if (hs) begin
                    hdr_k_d      = bus.s_data[31:27];
                    hdr_ref_d    = bus.s_data[26];
                    hdr_xref_d   = bus.s_data[25:16];
                    hdr_nwords_d = bus.s_data[15:0];
                    hdr_j_d      = cfg_j;
                    hdr_n_d      = cfg_n;
                    state_d      = HDR1;
                end
            end
            HDR1: begin
                if (hs) begin
                    beat_d = 16'd0;
                    if (hdr_illegal) begin
                        err_param_d = 1'b1;
                        state_d     = (hdr_nwords_q == 16'd0) ? HDR0 : SKIP;
                    end else begin
                        // Decoder parameters only move here, so they stay put for the whole block.
                        dec_k_d     = hdr_k_q;
                        dec_j_d     = hdr_j_q;
                        dec_n_d     = hdr_n_q;
                        dec_data2_d = bus.s_data[31:16];
                        if (hdr_ref_q) dec_xref_d = hdr_xref_q;
                        state_d     = STREAM;
                    end
                end
            end
            STREAM: begin
                if (hs) begin
                    dec_valid_d = 1'b1;
                    dec_data_d  = bus.s_data;
                    dec_first_d = hdr_ref_q && (beat_q < 16'(FIRST_HOLD));
                    beat_d      = beat_q + 16'd1;
                    if (last_beat) begin
                        timer_d = '0;
                        state_d = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                if (bus.dec_block_done) begin
                    blk_count_d = blk_count_q + CNT_W'(1);
                    state_d     = HDR0;
                end else if (timer_q == TMR_W'(DONE_TIMEOUT - 1)) begin
                    err_timeout_d = 1'b1;
                    state_d       = HDR0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            SKIP: begin
                if (hs) begin
                    beat_d = beat_q + 16'd1;
                    if (last_beat) state_d = HDR0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            hdr_k_q       <= '0;
            hdr_j_q       <= '0;
            hdr_n_q       <= '0;
            hdr_ref_q     <= 1'b0;
            hdr_xref_q    <= '0;
            hdr_nwords_q  <= '0;
            beat_q        <= '0;
            timer_q       <= '0;
            dec_valid_q   <= 1'b0;
            dec_first_q   <= 1'b0;
            dec_data_q    <= '0;
            dec_data2_q   <= '0;
            dec_k_q       <= '0;
            dec_j_q       <= '0;
            dec_n_q       <= '0;
            dec_xref_q    <= '0;
            blk_count_q   <= '0;
            err_param_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hdr_k_q       <= hdr_k_d;
            hdr_j_q       <= hdr_j_d;
            hdr_n_q       <= hdr_n_d;
            hdr_ref_q     <= hdr_ref_d;
            hdr_xref_q    <= hdr_xref_d;
            hdr_nwords_q  <= hdr_nwords_d;
            beat_q        <= beat_d;
            timer_q       <= timer_d;
            dec_valid_q   <= dec_valid_d;
            dec_first_q   <= dec_first_d;
            dec_data_q    <= dec_data_d;
            dec_data2_q   <= dec_data2_d;
            dec_k_q       <= dec_k_d;
            dec_j_q       <= dec_j_d;
            dec_n_q       <= dec_n_d;
            dec_xref_q    <= dec_xref_d;
            blk_count_q   <= blk_count_d;
            err_param_q   <= err_param_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign bus.s_ready   = s_ready;
    assign bus.dec_valid = dec_valid_q;
    assign bus.dec_first = dec_first_q;
    assign bus.dec_data  = dec_data_q;
    assign bus.dec_data2 = dec_data2_q;
    assign bus.dec_k     = dec_k_q;
    assign bus.dec_j     = dec_j_q;
    assign bus.dec_n     = dec_n_q;
    assign bus.dec_xref  = dec_xref_q;
    assign busy          = (state_q != IDLE) && (state_q != HDR0);
    assign blk_count     = blk_count_q;
    assign err_param     = err_param_q;
    assign err_timeout   = err_timeout_q;
endmodule
